// File: rtl/instr_mem_arbiter.sv
// Instruction memory arbiter: shares one single-ported instruction memory
// between the core fetch port and a bus/loader port.
//
// Grants are combinational from the requests and registered arbitration
// state. The bus wins by default. After STARVE_LIMIT consecutive denied
// core cycles the core wins once. A small owner FSM routes the read data,
// which returns one cycle after the grant, back to the port that issued the
// access.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   core_req_i/core_addr_i          core fetch request
//   core_gnt_o                      core request accepted this cycle
//   core_rvalid_o/core_rdata_o      core response
//   bus_req_i/addr/we/be/wdata      bus/loader request
//   bus_gnt_o                       bus request accepted this cycle
//   bus_rvalid_o/bus_rdata_o        bus response (rdata 0 for writes)
//   mem_en_o/addr/we/be/wdata       memory request
//   mem_rdata_i                     memory read data, one cycle after mem_en_o
module instr_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    core_req_i,
  input  logic [31:0]             core_addr_i,
  output logic                    core_gnt_o,
  output logic                    core_rvalid_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  input  logic                    bus_req_i,
  input  logic [31:0]             bus_addr_i,
  input  logic                    bus_we_i,
  input  logic [DATA_WIDTH/8-1:0] bus_be_i,
  input  logic [DATA_WIDTH-1:0]   bus_wdata_i,
  output logic                    bus_gnt_o,
  output logic                    bus_rvalid_o,
  output logic [DATA_WIDTH-1:0]   bus_rdata_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    BUS  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             bus_wr_q, bus_wr_d;
  logic             starved;

  // Address bits above ADDR_WIDTH-1 are deliberately ignored.
  if (ADDR_WIDTH < 32) begin : g_unused_addr
    logic unused_addr_bits;
    assign unused_addr_bits = ^{core_addr_i[31:ADDR_WIDTH], bus_addr_i[31:ADDR_WIDTH]};
  end

  // Arbitration and memory request mux; nothing is granted while in reset.
  always_comb begin
    starved     = (starve_q == CNT_MAX);
    core_gnt_o  = 1'b0;
    bus_gnt_o   = 1'b0;
    mem_en_o    = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;

    if (rst_n) begin
      if (core_req_i && (!bus_req_i || starved)) begin
        core_gnt_o = 1'b1;
      end else if (bus_req_i) begin
        bus_gnt_o = 1'b1;
      end
    end

    if (core_gnt_o) begin
      mem_en_o   = 1'b1;
      mem_addr_o = core_addr_i[ADDR_WIDTH-1:0];
      mem_be_o   = '1;
    end else if (bus_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = bus_addr_i[ADDR_WIDTH-1:0];
      mem_we_o    = bus_we_i;
      mem_be_o    = bus_be_i;
      mem_wdata_o = bus_wdata_i;
    end
  end

  // Response owner state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Starvation counter and write flag travelling with the bus grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      bus_wr_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      bus_wr_q <= bus_wr_d;
    end
  end

  // Next owner, counter update and response routing.
  always_comb begin
    state_d       = IDLE;
    starve_d      = '0;
    bus_wr_d      = 1'b0;
    core_rvalid_o = 1'b0;
    bus_rvalid_o  = 1'b0;
    core_rdata_o  = '0;
    bus_rdata_o   = '0;

    if (core_gnt_o) begin
      state_d = CORE;
    end else if (bus_gnt_o) begin
      state_d  = BUS;
      bus_wr_d = bus_we_i;
    end

    // Saturating count of consecutive denied core cycles.
    if (core_req_i && !core_gnt_o) begin
      starve_d = starved ? starve_q : starve_q + CNT_W'(1);
    end

    case (state_q)
      CORE: begin
        core_rvalid_o = 1'b1;
        core_rdata_o  = mem_rdata_i;
      end
      BUS: begin
        bus_rvalid_o = 1'b1;
        bus_rdata_o  = bus_wr_q ? '0 : mem_rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/instr_mem_arbiter.md
INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, is the byte-address width of the memory port; bit ADDR_WIDTH-1 selects boot ROM (1) or instruction RAM (0).
REQ-002 Parameter DATA_WIDTH, default 32, is the data width of all ports.
REQ-003 Parameter STARVE_LIMIT, default 4, is the number of consecutive denied core cycles after which the core wins arbitration.
REQ-004 Ports:
- clk  input  1  — the single clock; all state changes on its rising edge.
- rst_n  input  1  — asynchronous, active-low reset.
- core_req_i  input  1  — core instruction-fetch request.
- core_addr_i  input  32  — core fetch byte address.
- core_gnt_o  output  1  — core request accepted this cycle.
- core_rvalid_o  output  1  — core read data valid.
- core_rdata_o  output  DATA_WIDTH  — core read data.
- bus_req_i  input  1  — bus/loader request.
- bus_addr_i  input  32  — bus byte address.
- bus_we_i  input  1  — bus write enable.
- bus_be_i  input  DATA_WIDTH/8  — bus byte enables.
- bus_wdata_i  input  DATA_WIDTH  — bus write data.
- bus_gnt_o  output  1  — bus request accepted this cycle.
- bus_rvalid_o  output  1  — bus response valid.
- bus_rdata_o  output  DATA_WIDTH  — bus read data.
- mem_en_o  output  1  — memory access enable.
- mem_addr_o  output  ADDR_WIDTH  — memory byte address.
- mem_we_o  output  1  — memory write enable.
- mem_be_o  output  DATA_WIDTH/8  — memory byte enables.
- mem_wdata_o  output  DATA_WIDTH  — memory write data.
- mem_rdata_i  input  DATA_WIDTH  — memory read data, valid one cycle after mem_en_o.

Function
REQ-005 Each cycle the block shall grant at most one request; grants are combinational from the request inputs and the registered arbitration state.
REQ-006 Default priority: bus wins when bus_req_i and core_req_i are both high.
REQ-007 Starvation counter (width clog2(STARVE_LIMIT+1)): +1 each cycle core_req_i=1 and core_gnt_o=0; cleared when core is granted or core_req_i=0; saturates at STARVE_LIMIT.
REQ-008 When the counter equals STARVE_LIMIT and core_req_i=1, the core shall win over the bus in that cycle.
REQ-009 On a grant, mem_en_o=1 and mem_addr_o=granted addr[ADDR_WIDTH-1:0] in the same cycle; mem_en_o=0 when neither port is granted.
REQ-010 Core grants: mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
REQ-011 Bus grants: mem_we_o, mem_be_o and mem_wdata_o pass through from bus_we_i, bus_be_i and bus_wdata_i.
REQ-012 Response owner FSM, states IDLE/CORE/BUS: next state is CORE on a core grant, BUS on a bus grant, IDLE otherwise; the FSM updates every cycle.
REQ-013 Response latency:
- core_rvalid_o=1 exactly when state=CORE.
- bus_rvalid_o=1 exactly when state=BUS.
- Latency is one cycle after the grant, for both reads and writes.
REQ-014 The rdata output of the port that owns the response shall equal mem_rdata_i; the other port's rdata shall be 0.
REQ-015 Bus write responses shall drive bus_rdata_o=0; this requires registering the write flag with the grant.
REQ-016 Back-to-back grants on consecutive cycles are supported; a response and a new grant may coincide in the same cycle.
REQ-017 Address bits above ADDR_WIDTH-1 are ignored; no error response is produced.

Reset
REQ-018 While rst_n=0, the following shall be cleared immediately:
- FSM to IDLE
- starvation counter to 0
- core_rvalid_o and bus_rvalid_o to 0
- core_rdata_o and bus_rdata_o to 0
REQ-019 A response pending when reset asserts shall be dropped and never delivered.
REQ-020 During reset, grants and mem_en_o shall be 0 regardless of the request inputs.
REQ-021 After rst_n rises, the first grant may occur in the first clock edge cycle.

Verification
REQ-022 Core-only read: core_req_i=1, core_addr_i=0x0000_0104 for 1 cycle -> core_gnt_o=1, mem_addr_o=0x0104, mem_we_o=0; next cycle core_rvalid_o=1 and core_rdata_o=mem_rdata_i (0xDEADBEEF).
REQ-023 Contention: both ports request continuously, bus write to 0x0010 -> bus granted for 4 cycles, core granted in cycle 5, bus granted again in cycle 6.
REQ-024 Bus write: bus_we_i=1, bus_be_i=4'b0011, bus_wdata_i=0x1234_5678 -> mem_we_o=1, mem_be_o=4'b0011; next cycle bus_rvalid_o=1 with bus_rdata_o=0.
REQ-025 Back-to-back: core reads at 0x0000, 0x0004, 0x0008 on consecutive cycles -> three grants, then core_rvalid_o high for three consecutive cycles, each returning the matching data.
REQ-026 Boot ROM select: core_addr_i=0x0000_8000 -> mem_addr_o=0x8000, i.e. bit 15 set.
REQ-027 Reset mid-operation: rst_n=0 in the cycle after a core grant -> core_rvalid_o=0 immediately, and the response is not delivered after rst_n returns high.
